// File: rtl/branch_pc_unit.sv
// branch_pc_unit: owns the fetch PC. It turns comparator results and decoded
// jumps into fetch redirects, holds a redirect across fetch stalls, and keeps
// saturating counts of branches seen and branches taken.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_stall,
  input  logic             br_valid,
  input  logic             bcres,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_offset,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             pending,
  output logic             align_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  typedef enum logic {SEQ, PEND} state_t;

  state_t            state, state_d;
  logic [31:0]       tgt_r, tgt_d;
  logic [31:0]       pc_d;
  logic              flush_d;
  logic              align_d;
  logic [CNT_W-1:0]  br_d, tk_d;

  logic [31:0]       br_target;
  logic [31:0]       jmp_aligned;
  logic [31:0]       redirect;
  logic              taken;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A simultaneous jump overrides the branch; the branch still counts as seen.
  assign br_target   = br_pc + 32'd4 + (br_offset << 2);
  assign jmp_aligned = {jmp_target[31:2], 2'b00};
  assign taken       = jmp_valid | (br_valid & bcres);
  assign redirect    = jmp_valid ? jmp_aligned : br_target;

  // Next-state, next-PC and statistics; PEND ignores branch/jump inputs.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    tgt_d   = tgt_r;
    flush_d = 1'b0;
    align_d = align_err;
    br_d    = br_cnt;
    tk_d    = tk_cnt;
    case (state)
      SEQ: begin
        if (br_valid) begin
          br_d = sat_inc(br_cnt);
          if (bcres && !jmp_valid) tk_d = sat_inc(tk_cnt);
        end
        if (jmp_valid && (jmp_target[1:0] != 2'b00)) align_d = 1'b1;
        if (taken) begin
          flush_d = 1'b1;
          if (fetch_stall) begin
            tgt_d   = redirect;
            state_d = PEND;
          end else begin
            pc_d = redirect;
          end
        end else if (!fetch_stall) begin
          pc_d = pc + 32'd4;
        end
      end
      PEND: begin
        if (!fetch_stall) begin
          pc_d    = tgt_r;
          state_d = SEQ;
        end
      end
      default: state_d = SEQ;
    endcase
  end

  // State and output registers; reset also drops any deferred target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEQ;
      pc        <= RESET_PC;
      tgt_r     <= 32'h0;
      flush     <= 1'b0;
      align_err <= 1'b0;
      br_cnt    <= '0;
      tk_cnt    <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      tgt_r     <= tgt_d;
      flush     <= flush_d;
      align_err <= align_d;
      br_cnt    <= br_d;
      tk_cnt    <= tk_d;
    end
  end

  assign pending = (state == PEND);

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and redirect stage directly downstream of the branch comparator. Consumes the comparator's 1-bit condition result together with the decoded branch/jump information, computes the target, and owns the fetch PC register. Issues a one-cycle flush to kill the fall-through fetch on every taken redirect, defers redirects across fetch stalls, and keeps saturating branch statistics.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- fetch_stall  in  1  fetch cannot accept a new address; PC holds.
- br_valid  in  1  conditional branch resolving this cycle; one-cycle pulse per branch.
- bcres  in  1  condition result from the comparator; meaningful only with br_valid.
- br_pc  in  32  address of the branch instruction.
- br_offset  in  32  sign-extended word offset, imm16.
- jmp_valid  in  1  unconditional jump resolving this cycle; one-cycle pulse.
- jmp_target  in  32  absolute jump address.
- pc  out  32  current fetch address.
- flush  out  1  kill the instruction fetched at the fall-through path; registered.
- pending  out  1  a taken redirect is waiting on fetch_stall.
- align_err  out  1  sticky: a jump target had nonzero bits [1:0].
- br_cnt  out  CNT_W  accepted conditional branches, saturating.
- tk_cnt  out  CNT_W  taken conditional branches, saturating.

## Operation
- Branch target: br_pc + 4 + (br_offset << 2), modulo 2^32.
- Jump target: {jmp_target[31:2], 2'b00}. If jmp_target[1:0] != 0, align_err is set and stays set until reset.
- Taken event:
  - jmp_valid, or br_valid with bcres=1.
  - If jmp_valid and br_valid are asserted together, the jump wins.
  - In that case br_cnt still increments and tk_cnt does not.
- FSM states are SEQ and PEND.
- In SEQ, at each edge:
  - Taken event with fetch_stall=0: pc ← target, flush ← 1, stay in SEQ.
  - Taken event with fetch_stall=1: tgt_r ← target, flush ← 1, go to PEND.
  - No taken event with fetch_stall=0: pc ← pc + 4, wrapping 32'hFFFF_FFFC → 0.
  - No taken event with fetch_stall=1: pc holds.
- In PEND:
  - pc holds while fetch_stall=1.
  - At the first edge with fetch_stall=0: pc ← tgt_r, go to SEQ.
  - No second flush is issued.
  - br_valid and jmp_valid are ignored: no counting and no redirect, because the flushed path produces no valid branches.
- Counters:
  - br_cnt increments on every br_valid accepted in SEQ.
  - tk_cnt increments on every br_valid accepted in SEQ with bcres=1.
  - Both hold at all-ones.
- Reset values: pc = RESET_PC, state SEQ, pending 0, flush 0, align_err 0, br_cnt 0, tk_cnt 0, tgt_r 0. A reset during PEND discards the pending target.

## Timing
- Inputs are sampled at the rising edge; all outputs are registered.
- Redirect latency:
  - Taken event at edge E with no stall: pc = target and flush = 1 in the cycle after E.
  - flush is high for exactly one cycle per taken event.
- Stalled redirect:
  - flush = 1 and pending = 1 in the cycle after E.
  - pc reaches target one cycle after the first edge with fetch_stall=0.
  - pending drops in the same cycle.
- Not-taken branches add no bubble and never assert flush.
- Counter values update in the cycle after the accepting edge.

## Test plan
- Reset, then run free with no branches for 3 cycles.
  - pc = 0, then 4, 8, 12; flush stays 0.
- Taken branch: br_pc=0x100, br_offset=0xFFFF_FFFC, bcres=1, no stall.
  - Next cycle: pc = 0x0F4, flush = 1 for one cycle.
  - br_cnt = 1, tk_cnt = 1.
- Not-taken branch with bcres=0 at pc=0x20.
  - pc = 0x24, flush = 0, br_cnt increments, tk_cnt unchanged.
- Jump with jmp_target=0x2002 while fetch_stall=1 for 3 cycles.
  - flush pulses once; pending = 1 for 3 cycles with pc held.
  - Then pc = 0x2000, pending = 0, align_err = 1.
- br_valid+bcres=1 pulsed during PEND, plus simultaneous jmp_valid+br_valid in SEQ.
  - The PEND branch is ignored: counters unchanged.
  - The simultaneous case redirects to the jump target, with br_cnt +1 and tk_cnt +0.
- rst_n=0 for one edge while in PEND.
  - pc = RESET_PC, pending = 0, counters 0, align_err 0.
  - After release, pc advances 0 → 4.
- Wrap: pc=0xFFFF_FFFC with no branch gives pc = 0. Preload br_cnt and tk_cnt to 0xFFFF; a taken branch leaves both at 0xFFFF.
